// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner, doubleword fetch and 2-wide instruction queue for decode
// Bit vectors use big-endian numbering: bit 0 is the MSB and the lower-address word.
module fetch_queue #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    output logic             mem_read_en,
    output logic [0:60]      mem_read_addr,
    input  logic [0:63]      mem_read_data,
    input  logic [1:0]       deq,
    input  logic             redirect,
    input  logic [0:63]      redirect_pc,
    output logic [0:31]      inst0,
    output logic [0:63]      pc0,
    output logic             valid0,
    output logic [0:31]      inst1,
    output logic [0:63]      pc1,
    output logic             valid1,
    output logic [CNT_W-1:0] count
);

    logic [0:31]      inst_q [DEPTH];
    logic [0:63]      pc_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [CNT_W-1:0] count_q, count_d, deq_eff;
    logic [0:63]      fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       deq_req, enq_n;
    logic [CNT_W:0]   need;
    logic             wr_en;
    logic             unused_bits;

    assign unused_bits = ^redirect_pc[62:63];

    always_comb begin
        deq_req = (deq == 2'd3) ? 2'd2 : deq;
        deq_eff = (CNT_W'(deq_req) > count_q) ? count_q : CNT_W'(deq_req);
        enq_n   = inflight_q ? (inflight_pc_q[61] ? 2'd1 : 2'd2) : 2'd0;
        // Reserve room for the return still in flight plus the one about to be issued.
        need    = {1'b0, count_q} + (inflight_q ? (CNT_W+1)'(2) : (CNT_W+1)'(0)) + (CNT_W+1)'(2);
        mem_read_en = ~reset & ~redirect & ~stop & (need <= (CNT_W+1)'(DEPTH));

        head_d        = head_q + PTR_W'(deq_eff);
        tail_d        = tail_q + PTR_W'(enq_n);
        count_d       = count_q + CNT_W'(enq_n) - deq_eff;
        inflight_d    = mem_read_en;
        inflight_pc_d = inflight_pc_q;
        fetch_pc_d    = fetch_pc_q;
        if (mem_read_en) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = {fetch_pc_q[0:60], 3'b000} + 64'd8;
        end
        if (redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[0:61], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign wr_en = ~reset & ~redirect & inflight_q;
    assign tail1 = tail_q + PTR_W'(1);

    // A word-aligned target keeps only the upper-address half of its doubleword.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!inflight_pc_q[61]) begin
                inst_q[tail_q] <= mem_read_data[0:31];
                pc_q[tail_q]   <= inflight_pc_q;
                inst_q[tail1]  <= mem_read_data[32:63];
                pc_q[tail1]    <= inflight_pc_q + 64'd4;
            end else begin
                inst_q[tail_q] <= mem_read_data[32:63];
                pc_q[tail_q]   <= inflight_pc_q;
            end
        end
    end

    assign head1         = head_q + PTR_W'(1);
    assign mem_read_addr = fetch_pc_q[0:60];
    assign inst0         = inst_q[head_q];
    assign pc0           = pc_q[head_q];
    assign inst1         = inst_q[head1];
    assign pc1           = pc_q[head1];
    assign valid0        = (count_q >= CNT_W'(1));
    assign valid1        = (count_q >= CNT_W'(2));
    assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized bench for fetch_queue against a queue-of-PCs reference model
module tb_fetch_queue;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, stop, redirect, mem_read_en, valid0, valid1;
    logic [60:0] mem_read_addr;
    logic [63:0] mem_read_data, redirect_pc, pc0, pc1;
    logic [1:0]  deq;
    logic [31:0] inst0, inst1;
    logic [6:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(6), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .stop(stop),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
        .deq(deq), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst0(inst0), .pc0(pc0), .valid0(valid0),
        .inst1(inst1), .pc1(pc1), .valid1(valid1), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory image: the instruction stored at byte address a is a pure function of a.
    function automatic logic [31:0] word(input logic [63:0] a);
        return 32'h38600001 + 32'(a >> 2) * 32'h00200001;
    endfunction

    // Reference model: the queue holds PCs; each entry's instruction is word(pc).
    logic [63:0] mq[$];
    logic [63:0] m_fpc, m_ipc;
    bit          m_inf;
    bit          m_prev_issue;
    logic [63:0] m_prev_addr;
    bit          chk_on;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check("count", 64'(count), 64'(mq.size()));
        check("valid0", 64'(valid0), 64'(mq.size() >= 1));
        check("valid1", 64'(valid1), 64'(mq.size() >= 2));
        if (mq.size() >= 1) begin
            check("pc0", pc0, mq[0]);
            check("inst0", 64'(inst0), 64'(word(mq[0])));
        end
        if (mq.size() >= 2) begin
            check("pc1", pc1, mq[1]);
            check("inst1", 64'(inst1), 64'(word(mq[1])));
        end
    endtask

    // One clock cycle, entered and left just after a negedge.
    task automatic step(input bit rst, input bit rd, input bit stp, input logic [1:0] dq,
                        input logic [63:0] rpc);
        bit iss;
        int d;
        if (chk_on) check_state();
        reset = rst; redirect = rd; stop = stp; deq = dq; redirect_pc = rpc;
        mem_read_data = m_prev_issue ? {word({m_prev_addr, 3'b000}), word({m_prev_addr, 3'b100})}
                                     : {$urandom, $urandom};
        iss = !rst && !rd && !stp && (mq.size() + 2 * int'(m_inf) + 2 <= DEPTH);
        #1;
        if (chk_on) begin
            check("mem_read_en", 64'(mem_read_en), 64'(iss));
            if (iss) check("mem_read_addr", 64'(mem_read_addr), m_fpc >> 3);
        end
        m_prev_issue = iss;
        m_prev_addr  = m_fpc >> 3;
        if (rst) begin
            mq.delete(); m_inf = 0; m_fpc = 0; m_ipc = 0;
        end else if (rd) begin
            mq.delete(); m_inf = 0; m_fpc = rpc & ~64'd3;
        end else begin
            d = (dq == 2'd3) ? 2 : int'(dq);
            if (d > mq.size()) d = mq.size();
            repeat (d) void'(mq.pop_front());
            if (m_inf) begin
                mq.push_back(m_ipc);
                if (!m_ipc[2]) mq.push_back(m_ipc + 4);
            end
            m_inf = iss;
            if (iss) begin
                m_ipc = m_fpc;
                m_fpc = (m_fpc & ~64'd7) + 8;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        chk_on = 0; m_prev_issue = 0; m_prev_addr = 0;
        m_fpc = 0; m_ipc = 0; m_inf = 0;
        reset = 1; redirect = 0; stop = 0; deq = 0; redirect_pc = 0; mem_read_data = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_on = 1;

        // Cold start: first pair visible two cycles after the first read.
        check("reset_count", 64'(count), 64'd0);
        check("reset_valid0", 64'(valid0), 64'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("first_valid1", 64'(valid1), 64'd1);
        check("first_inst0", 64'(inst0), 64'h38600001);
        check("first_pc0", pc0, 64'd0);
        check("first_inst1", 64'(inst1), 64'h38800002);
        check("first_pc1", pc1, 64'd4);
        check("first_count", 64'(count), 64'd2);

        // No consumption: the queue fills to exactly DEPTH and fetch stalls.
        repeat (80) step(0, 0, 0, 0, 0);
        check("full_count", 64'(count), 64'd64);
        check("full_pc0", pc0, 64'd0);
        check("full_inst0", 64'(inst0), 64'h38600001);
        #1 check("full_no_read", 64'(mem_read_en), 64'd0);

        // Steady trickle across pointer wrap.
        repeat (100) step(0, 0, 0, 2'd1, 0);
        repeat (6) step(0, 0, 0, 2'd2, 0);

        // Redirect to a word-aligned target while a read is outstanding.
        step(0, 1, 0, 2'd2, 64'h107);
        check("redir_count", 64'(count), 64'd0);
        check("redir_valid0", 64'(valid0), 64'd0);
        redirect = 0; deq = 0;
        #1;
        check("redir_read_en", 64'(mem_read_en), 64'd1);
        check("redir_read_addr", 64'(mem_read_addr), 64'h20);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("redir_single_count", 64'(count), 64'd1);
        check("redir_pc0", pc0, 64'h104);
        step(0, 0, 0, 2'd1, 0);
        check("redir_next_pc0", pc0, 64'h108);

        // Randomized mix of consumption, stalls, redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_rd, r_stp;
            logic [63:0] r_pc;
            r_rst = ($urandom_range(0, 99) < 1);
            r_rd  = ($urandom_range(0, 99) < 3);
            r_stp = ($urandom_range(0, 99) < 15);
            r_pc  = {$urandom, $urandom} & 64'h0000_0000_00FF_FFFF;
            step(r_rst, r_rd, r_stp, 2'($urandom_range(0, 3)), r_pc);
        end
        step(0, 0, 1, 0, 0);
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
